// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and source indices for the common data bus arbiter.
// Round-robin arbitration is selected by defining CDB_ROUND_ROBIN_EN.
package cdb_arbiter_pkg;

  localparam int ROB_POS_WID = 4;
  localparam int DATA_WID    = 32;
  localparam int ADDR_WID    = 32;
  localparam int NUM_CDB_SRC = 2;
  localparam int CDB_SRC_ALU = 0;
  localparam int CDB_SRC_LSB = 1;

  // Width of a source index; a single-source build still gets one bit.
  function automatic int src_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-source handshake and CDB broadcast bundle.
// master = functional-unit side / CDB consumers, slave = arbiter.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = NUM_CDB_SRC,
  parameter int ROB_POS_W = ROB_POS_WID,
  parameter int DATA_W    = DATA_WID,
  parameter int ADDR_W    = ADDR_WID
);
  localparam int SRC_W = src_idx_w(NUM_SRC);

  logic [NUM_SRC-1:0]           src_valid;
  logic [NUM_SRC-1:0]           src_ready;
  logic [NUM_SRC*ROB_POS_W-1:0] src_rob_pos;
  logic [NUM_SRC*DATA_W-1:0]    src_val;
  logic [NUM_SRC-1:0]           src_jump;
  logic [NUM_SRC*ADDR_W-1:0]    src_pc;

  logic                         cdb_valid;
  logic [ROB_POS_W-1:0]         cdb_rob_pos;
  logic [DATA_W-1:0]            cdb_val;
  logic                         cdb_jump;
  logic [ADDR_W-1:0]            cdb_pc;
  logic [SRC_W-1:0]             cdb_src;

  modport master (
    output src_valid, src_rob_pos, src_val, src_jump, src_pc,
    input  src_ready,
    input  cdb_valid, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc, cdb_src
  );

  modport slave (
    input  src_valid, src_rob_pos, src_val, src_jump, src_pc,
    output src_ready,
    output cdb_valid, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc, cdb_src
  );

endinterface

// File: rtl/cdb_arbiter_pick.sv
// Combinational one-hot picker: first requester at or after base, wrapping.
// A base of 0 gives plain lowest-index priority.
module cdb_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!gnt_any && req[i] && (i == ((int'(base) + k) % N))) begin
          gnt[i]  = 1'b1;
          gnt_idx = IW'(i);
          gnt_any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one-entry holding slot per source, one registered broadcast per cycle.
// Define CDB_ROUND_ROBIN_EN for round-robin; default is fixed priority (ALU first).
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = NUM_CDB_SRC,
  parameter int ROB_POS_W = ROB_POS_WID,
  parameter int DATA_W    = DATA_WID,
  parameter int ADDR_W    = ADDR_WID
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         rollback,
  cdb_arbiter_if.slave bus
);

  localparam int SRC_W = src_idx_w(NUM_SRC);

  logic [NUM_SRC-1:0]   occ;
  logic [ROB_POS_W-1:0] slot_pos  [NUM_SRC];
  logic [DATA_W-1:0]    slot_val  [NUM_SRC];
  logic                 slot_jump [NUM_SRC];
  logic [ADDR_W-1:0]    slot_pc   [NUM_SRC];

  logic [NUM_SRC-1:0]   gnt;
  logic [SRC_W-1:0]     gnt_idx;
  logic                 gnt_any;
  logic [SRC_W-1:0]     pick_base;
  logic [NUM_SRC-1:0]   push;

`ifdef CDB_ROUND_ROBIN_EN
  logic [SRC_W-1:0]     rr_ptr;

  assign pick_base = (rr_ptr == SRC_W'(NUM_SRC - 1)) ? '0 : rr_ptr + 1'b1;
`else
  assign pick_base = '0;
`endif

  cdb_pick #(
    .N  (NUM_SRC),
    .IW (SRC_W)
  ) u_pick (
    .req     (occ),
    .base    (pick_base),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // A slot being granted this cycle can take a new result at the same edge.
  assign bus.src_ready = (rst || !rdy || rollback) ? '0 : (~occ | gnt);
  assign push          = bus.src_valid & bus.src_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ             <= '0;
      bus.cdb_valid   <= 1'b0;
      bus.cdb_rob_pos <= '0;
      bus.cdb_val     <= '0;
      bus.cdb_jump    <= 1'b0;
      bus.cdb_pc      <= '0;
      bus.cdb_src     <= '0;
`ifdef CDB_ROUND_ROBIN_EN
      rr_ptr          <= SRC_W'(NUM_SRC - 1);
`endif
    end else if (rollback) begin
      occ           <= '0;
      bus.cdb_valid <= 1'b0;
    end else if (rdy) begin
      bus.cdb_valid <= gnt_any;
      if (gnt_any) begin
        bus.cdb_rob_pos <= slot_pos[gnt_idx];
        bus.cdb_val     <= slot_val[gnt_idx];
        bus.cdb_jump    <= slot_jump[gnt_idx];
        bus.cdb_pc      <= slot_pc[gnt_idx];
        bus.cdb_src     <= gnt_idx;
`ifdef CDB_ROUND_ROBIN_EN
        rr_ptr          <= gnt_idx;
`endif
      end
      occ <= push | (occ & ~gnt);
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) begin
          slot_pos[i]  <= bus.src_rob_pos[i*ROB_POS_W +: ROB_POS_W];
          slot_val[i]  <= bus.src_val[i*DATA_W +: DATA_W];
          slot_jump[i] <= bus.src_jump[i];
          slot_pc[i]   <= bus.src_pc[i*ADDR_W +: ADDR_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter; expectations follow CDB_ROUND_ROBIN_EN.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst, rdy, rollback;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  cdb_arbiter_if #(.NUM_SRC(2), .ROB_POS_W(4), .DATA_W(32), .ADDR_W(32)) bus ();

  cdb_arbiter #(.NUM_SRC(2), .ROB_POS_W(4), .DATA_W(32), .ADDR_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_src();
    bus.src_valid   = '0;
    bus.src_rob_pos = '0;
    bus.src_val     = '0;
    bus.src_jump    = '0;
    bus.src_pc      = '0;
  endtask

  task automatic offer(input int i, input logic [3:0] pos, input logic [31:0] val,
                       input logic jump, input logic [31:0] pc);
    bus.src_valid[i]          = 1'b1;
    bus.src_rob_pos[i*4 +: 4] = pos;
    bus.src_val[i*32 +: 32]   = val;
    bus.src_jump[i]           = jump;
    bus.src_pc[i*32 +: 32]    = pc;
  endtask

  task automatic reset_dut();
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    clear_src();
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    clear_src();
    tick();
    tick();
    total_cnt++;
    if (bus.src_ready !== 2'b00) $display("FAIL reset_ready_in_rst got=%b exp=00", bus.src_ready);
    else pass_cnt++;
    total_cnt++;
    if ({bus.cdb_valid, bus.cdb_rob_pos, bus.cdb_val, bus.cdb_jump, bus.cdb_pc, bus.cdb_src} !== '0)
      $display("FAIL reset_cdb_regs got v=%b pos=%h val=%h j=%b pc=%h src=%h exp all zero",
               bus.cdb_valid, bus.cdb_rob_pos, bus.cdb_val, bus.cdb_jump, bus.cdb_pc, bus.cdb_src);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (bus.src_ready !== 2'b11) $display("FAIL reset_ready_after got=%b exp=11", bus.src_ready);
    else pass_cnt++;

    offer(CDB_SRC_ALU, 4'd3, 32'h55, 1'b1, 32'h100);
    tick();
    clear_src();
    total_cnt++;
    if (bus.cdb_valid !== 1'b0) $display("FAIL single_latency got=%b exp=0", bus.cdb_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bus.cdb_valid, bus.cdb_rob_pos, bus.cdb_val, bus.cdb_jump, bus.cdb_pc, bus.cdb_src}
        !== {1'b1, 4'd3, 32'h55, 1'b1, 32'h100, 1'b0})
      $display("FAIL single_bcast got v=%b pos=%0d val=%h j=%b pc=%h src=%0d exp v=1 pos=3 val=55 j=1 pc=100 src=0",
               bus.cdb_valid, bus.cdb_rob_pos, bus.cdb_val, bus.cdb_jump, bus.cdb_pc, bus.cdb_src);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bus.cdb_valid, bus.cdb_rob_pos} !== {1'b0, 4'd3})
      $display("FAIL single_pulse_end got v=%b pos=%0d exp v=0 pos=3 (held)", bus.cdb_valid, bus.cdb_rob_pos);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    reset_dut();
    offer(CDB_SRC_ALU, 4'd1, 32'h11, 1'b0, 32'h0);
    offer(CDB_SRC_LSB, 4'd2, 32'h22, 1'b0, 32'h0);
    tick();
    clear_src();
    total_cnt++;
    if (bus.src_ready !== 2'b01) $display("FAIL simul_ready_both_full got=%b exp=01", bus.src_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bus.cdb_valid, bus.cdb_rob_pos, bus.cdb_src} !== {1'b1, 4'd1, 1'b0})
      $display("FAIL simul_first got v=%b pos=%0d src=%0d exp v=1 pos=1 src=0",
               bus.cdb_valid, bus.cdb_rob_pos, bus.cdb_src);
    else pass_cnt++;
    total_cnt++;
    if (bus.src_ready !== 2'b11) $display("FAIL simul_ready_lsb_granted got=%b exp=11", bus.src_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bus.cdb_valid, bus.cdb_rob_pos, bus.cdb_src} !== {1'b1, 4'd2, 1'b1})
      $display("FAIL simul_second got v=%b pos=%0d src=%0d exp v=1 pos=2 src=1",
               bus.cdb_valid, bus.cdb_rob_pos, bus.cdb_src);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.cdb_valid !== 1'b0) $display("FAIL simul_idle got=%b exp=0", bus.cdb_valid);
    else pass_cnt++;
  endtask

  task automatic test_starvation();
    logic       exp_src;
    logic [1:0] exp_rdy;
    logic [3:0] exp_pos;
    reset_dut();
    offer(CDB_SRC_ALU, 4'd5, 32'hA0, 1'b0, 32'h0);
    offer(CDB_SRC_LSB, 4'd10, 32'hB0, 1'b0, 32'h0);
    tick();
    for (int k = 1; k <= 7; k++) begin
      tick();
`ifdef CDB_ROUND_ROBIN_EN
      exp_src = ((k - 1) % 2 == 1);
      exp_rdy = exp_src ? 2'b01 : 2'b10;
`else
      exp_src = 1'b0;
      exp_rdy = 2'b01;
`endif
      exp_pos = exp_src ? 4'd10 : 4'd5;
      total_cnt++;
      if ({bus.cdb_valid, bus.cdb_src, bus.cdb_rob_pos} !== {1'b1, exp_src, exp_pos})
        $display("FAIL starve_bcast_%0d got v=%b src=%0d pos=%0d exp v=1 src=%0d pos=%0d",
                 k, bus.cdb_valid, bus.cdb_src, bus.cdb_rob_pos, exp_src, exp_pos);
      else pass_cnt++;
      total_cnt++;
      if (bus.src_ready !== exp_rdy)
        $display("FAIL starve_ready_%0d got=%b exp=%b", k, bus.src_ready, exp_rdy);
      else pass_cnt++;
    end
    clear_src();
    tick();
`ifdef CDB_ROUND_ROBIN_EN
    exp_src = 1'b1;
`else
    exp_src = 1'b0;
`endif
    total_cnt++;
    if ({bus.cdb_valid, bus.cdb_src} !== {1'b1, exp_src})
      $display("FAIL starve_drain_a got v=%b src=%0d exp v=1 src=%0d", bus.cdb_valid, bus.cdb_src, exp_src);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bus.cdb_valid, bus.cdb_src} !== {1'b1, ~exp_src})
      $display("FAIL starve_drain_b got v=%b src=%0d exp v=1 src=%0d", bus.cdb_valid, bus.cdb_src, ~exp_src);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.cdb_valid !== 1'b0) $display("FAIL starve_idle got=%b exp=0", bus.cdb_valid);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    reset_dut();
    for (int k = 0; k <= 5; k++) begin
      offer(CDB_SRC_ALU, 4'(k), 32'(k * 3), 1'b0, 32'h0);
      total_cnt++;
      if (bus.src_ready[0] !== 1'b1) $display("FAIL b2b_ready_%0d got=%b exp=1", k, bus.src_ready[0]);
      else pass_cnt++;
      tick();
      if (k >= 1) begin
        total_cnt++;
        if ({bus.cdb_valid, bus.cdb_rob_pos, bus.cdb_val} !== {1'b1, 4'(k - 1), 32'((k - 1) * 3)})
          $display("FAIL b2b_bcast_%0d got v=%b pos=%0d val=%0d exp v=1 pos=%0d val=%0d",
                   k, bus.cdb_valid, bus.cdb_rob_pos, bus.cdb_val, k - 1, (k - 1) * 3);
        else pass_cnt++;
      end
    end
    clear_src();
    tick();
    total_cnt++;
    if ({bus.cdb_valid, bus.cdb_rob_pos} !== {1'b1, 4'd5})
      $display("FAIL b2b_last got v=%b pos=%0d exp v=1 pos=5", bus.cdb_valid, bus.cdb_rob_pos);
    else pass_cnt++;
  endtask

  task automatic test_rollback();
    reset_dut();
    offer(CDB_SRC_ALU, 4'd7, 32'h7, 1'b0, 32'h0);
    offer(CDB_SRC_LSB, 4'd8, 32'h8, 1'b0, 32'h0);
    tick();
    clear_src();
    rollback = 1'b1;
    offer(CDB_SRC_ALU, 4'd9, 32'h9, 1'b0, 32'h0);
    #1;
    total_cnt++;
    if (bus.src_ready !== 2'b00) $display("FAIL rb_ready_during got=%b exp=00", bus.src_ready);
    else pass_cnt++;
    tick();
    rollback = 1'b0;
    clear_src();
    total_cnt++;
    if (bus.cdb_valid !== 1'b0) $display("FAIL rb_valid_next got=%b exp=0", bus.cdb_valid);
    else pass_cnt++;
    #1;
    total_cnt++;
    if (bus.src_ready !== 2'b11) $display("FAIL rb_ready_after got=%b exp=11", bus.src_ready);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      tick();
      total_cnt++;
      if (bus.cdb_valid !== 1'b0) $display("FAIL rb_no_stale_%0d got=%b exp=0", k, bus.cdb_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_rdy_stall();
    reset_dut();
    offer(CDB_SRC_ALU, 4'd4, 32'hAB, 1'b0, 32'h0);
    tick();
    clear_src();
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total_cnt++;
      if (bus.src_ready !== 2'b00) $display("FAIL stall_ready_%0d got=%b exp=00", k, bus.src_ready);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.cdb_valid !== 1'b0) $display("FAIL stall_valid_%0d got=%b exp=0", k, bus.cdb_valid);
      else pass_cnt++;
    end
    rdy = 1'b1;
    #1;
    total_cnt++;
    if (bus.src_ready !== 2'b11) $display("FAIL stall_ready_resume got=%b exp=11", bus.src_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bus.cdb_valid, bus.cdb_rob_pos, bus.cdb_val, bus.cdb_src} !== {1'b1, 4'd4, 32'hAB, 1'b0})
      $display("FAIL stall_bcast got v=%b pos=%0d val=%h src=%0d exp v=1 pos=4 val=ab src=0",
               bus.cdb_valid, bus.cdb_rob_pos, bus.cdb_val, bus.cdb_src);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.cdb_valid !== 1'b0) $display("FAIL stall_pulse_end got=%b exp=0", bus.cdb_valid);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_starvation();
    test_back_to_back();
    test_rollback();
    test_rdy_stall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single common data bus (CDB) result broadcast between functional units: ALU, load/store buffer and any later units. Each source pushes a completed result through a valid/ready handshake into a one-entry holding slot. The arbiter grants one occupied slot per cycle and drives the registered broadcast consumed by the reorder buffer, reservation station and load/store buffer. A rollback flushes all in-flight results.

## Interface
Parameters:
- NUM_SRC, 2, number of result sources (index 0 = ALU, 1 = LSB)
- ROB_POS_W, 4, ROB index width
- DATA_W, 32, result value width
- ADDR_W, 32, target PC width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global enable; low = freeze all state
- rollback  in  1  mispredict flush
- src_valid  in  NUM_SRC  per-source result valid
- src_ready  out  NUM_SRC  per-source accept
- src_rob_pos  in  NUM_SRC*ROB_POS_W  packed, source i at bits [i*ROB_POS_W +: ROB_POS_W]
- src_val  in  NUM_SRC*DATA_W  packed result values
- src_jump  in  NUM_SRC  branch-taken result (0 for non-branch sources)
- src_pc  in  NUM_SRC*ADDR_W  packed resolved target PC
- cdb_valid  out  1  broadcast valid
- cdb_rob_pos  out  ROB_POS_W  broadcast ROB index
- cdb_val  out  DATA_W  broadcast value
- cdb_jump  out  1  broadcast jump flag
- cdb_pc  out  ADDR_W  broadcast target PC
- cdb_src  out  clog2(NUM_SRC) (min 1)  index of the granted source

## Operation
- Per source i: slot occ[i] plus captured {rob_pos, val, jump, pc}.
- src_ready[i] = !rst && rdy && !rollback && (!occ[i] || grant[i]). This is combinational, so one source can sustain one result per cycle.
- Transfer when src_valid[i] && src_ready[i]: the slot is written at the clock edge and occ[i] is set.
- Grant: exactly one occupied slot per cycle, chosen by the pick policy (see Configuration). No slot occupied means no grant.
- At an edge with a grant, the cdb_* registers load the winner's slot and cdb_valid is set to 1. The winner's occ clears unless it is refilled at the same edge (refill wins).
- At an edge without a grant, cdb_valid is set to 0 and the cdb data fields hold their previous values.
- Losing slots keep their contents; their src_ready stays 0 until they are granted.
- rollback = 1 at an edge: all occ clear, cdb_valid is set to 0, and any handshake offered in that cycle is discarded. The pointer is unchanged.
- rdy = 0: no state changes; src_ready = 0; outputs hold.
- rst: all occ = 0, cdb_valid = 0, cdb_rob_pos = 0, cdb_val = 0, cdb_jump = 0, cdb_pc = 0, cdb_src = 0, rr_ptr = NUM_SRC-1. src_ready = 0 while rst is high and all 1 after it.
- rst has priority over rollback, and rollback has priority over rdy.

## Timing
- Latency: a result accepted at edge E0 appears on the CDB after edge E1 at the earliest, for one cycle.
- Each additional competing occupied slot ahead of it in pick order adds 1 cycle.
- A result offered in the same cycle as a grant of that slot is accepted, so the slot never bubbles.
- Aggregate throughput: 1 broadcast per cycle.
- cdb_valid is a one-cycle pulse per result. Consumers must sample it every cycle; there is no backpressure from the CDB.

## Configuration
- CDB_ROUND_ROBIN_EN defined:
  - Search starts at index rr_ptr+1, wrapping modulo NUM_SRC.
  - rr_ptr updates to the granted index on each grant.
  - rr_ptr is held on cycles without a grant and across rdy = 0.
- CDB_ROUND_ROBIN_EN undefined:
  - Fixed priority: the lowest occupied index wins.
  - rr_ptr is absent.

## Structure
- Shared package/macros: ROB_POS_WID, DATA_WID, ADDR_WID, NUM_CDB_SRC, CDB_SRC_ALU = 0, CDB_SRC_LSB = 1.
- Sub-module cdb_pick: combinational one-hot picker taking a request vector and a base index, returning grant one-hot and grant index. With a base of 0 it implements fixed priority.
- The top level holds the slots, rr_ptr and the output registers.

## Test plan
- Reset release: after rst, src_ready = 2'b11 and cdb_valid = 0. One ALU push {pos 3, val 0x55, jump 1, pc 0x100} gives cdb_valid = 1 for exactly one cycle with those fields and cdb_src = 0.
- Simultaneous push: ALU pos 1 and LSB pos 2 at the same edge.
  - RR enabled: pos 1 broadcasts, then pos 2. LSB src_ready stays 0 for one cycle.
  - RR disabled: same order.
- Starvation: ALU and LSB both push every cycle for 8 cycles.
  - RR enabled: cdb_src alternates 0,1,0,1…
  - RR disabled: LSB never wins until ALU stops.
- Back-to-back single source: ALU pushes pos 0..5 on consecutive cycles. src_ready is never 0, and cdb_rob_pos = 0..5 on consecutive cycles.
- Rollback: both slots full, rollback pulses. cdb_valid = 0 next cycle and no stale broadcast follows. A push offered during the rollback cycle is dropped.
- rdy stall: rdy = 0 for 3 cycles with a slot full. No broadcast, src_ready = 0. The broadcast appears one cycle after rdy returns.
